// File: rtl/stream_pkg.sv
// ============================================================================
// Module      : stream_pkg
// Description : Shared stream types and constants for the valid/ready blocks.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package stream_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/ready_skid_buffer.sv
// ============================================================================
// Module      : ready_skid_buffer
// Description : Two-entry valid/ready slice with a registered in_ready path.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ready_skid_buffer
  import stream_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            level
);

  skid_state_e           state_q, state_d;
  logic [data_width-1:0] main_q, main_d;
  logic [data_width-1:0] skid_q, skid_d;
  logic                  w_in_fire;
  logic                  w_out_fire;

  // Handshake outputs come only from the state flop, never from out_ready.
  assign in_ready   = (state_q != FULL);
  assign out_valid  = (state_q != EMPTY);
  assign out_data   = main_q;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    level = 2'd0;
    case (state_q)
      EMPTY:   level = 2'd0;
      BUSY:    level = 2'd1;
      FULL:    level = 2'(SKID_DEPTH);
      default: level = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (w_in_fire) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (w_in_fire && w_out_fire) begin
          main_d = in_data;
        end else if (w_in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (w_out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Skid beat is always the younger one, so it moves up to the head.
        if (w_out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/ready_skid_buffer.md
# ready_skid_buffer

Two-entry valid/ready register slice that registers the backward (ready) path of a stream, complementing the team's forward-registered single-stage pipeline. It sits between a producer and a consumer on long or congested streams so that `in_ready` is driven from a flop and never combinationally from `out_ready`. Full throughput of one beat per cycle is sustained, and no beat is dropped or duplicated under arbitrary backpressure.

## Interface
- `data_width`, 8, payload width in bits
- `clk`  in  1  sole clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset, sampled on `clk` rising edge
- `in_valid`  in  1  producer has a beat on `in_data`
- `in_data`  in  data_width  producer payload
- `in_ready`  out  1  buffer accepts a beat this cycle; driven purely from state
- `out_valid`  out  1  buffer presents a beat on `out_data`
- `out_data`  out  data_width  payload at head of buffer
- `out_ready`  in  1  consumer accepts the beat this cycle
- `level`  out  2  number of held beats: 0, 1 or 2

## Operation
- Storage:
  - `main_q` is the output register and drives `out_data`.
  - `skid_q` holds the overflow beat.
- Fire rules:
  - `in_fire` = `in_valid` & `in_ready`
  - `out_fire` = `out_valid` & `out_ready`
- States:
  - EMPTY: level 0, `in_ready`=1, `out_valid`=0
  - BUSY: level 1, `in_ready`=1, `out_valid`=1
  - FULL: level 2, `in_ready`=0, `out_valid`=1
- Transitions from EMPTY:
  - `in_fire` -> BUSY, `main_q`<=`in_data`
  - otherwise stay EMPTY
- Transitions from BUSY:
  - `in_fire` & `out_fire` -> stay BUSY, `main_q`<=`in_data`
  - `in_fire` only -> FULL, `skid_q`<=`in_data`
  - `out_fire` only -> EMPTY
  - neither -> stay BUSY, hold
- Transitions from FULL:
  - `out_fire` -> BUSY, `main_q`<=`skid_q`
  - otherwise stay FULL, hold
  - `in_valid` is ignored because `in_ready`=0.
- Ordering is strict FIFO: `skid_q` is always younger than `main_q`.
- `out_data` is stable and `out_valid` does not drop while `out_valid`=1 and `out_ready`=0.
- `out_data` is don't-care when `out_valid`=0; the implementation holds the last value.
- `in_valid` asserted with `in_ready`=0 is legal. The producer holds the beat, and the buffer takes it on a later `in_ready` cycle.

## Timing
- Latency: a beat accepted on edge N appears on `out_data` with `out_valid`=1 after edge N, so it can fire on edge N+1.
- Throughput: 1 beat/cycle in steady state when `out_ready`=1.
- `in_ready` has zero combinational dependence on `out_ready` or `in_valid`. This is the purpose of the block.
- `out_valid` and `out_data` are registered.
- Backpressure reaches the producer one cycle late: after `out_ready` falls, the buffer absorbs exactly one extra beat into `skid_q`.
- Reset, while `rst`=1 at an edge:
  - state<=EMPTY; `main_q`, `skid_q`<=0
  - all inputs ignored
- Reset values (first cycle after the reset edge):
  - `out_valid`=0, `out_data`=0
  - `in_ready`=1, `level`=0
- Reset asserted mid-operation: held beats are discarded with no output fire, and the buffer returns to EMPTY on that edge.

## Structure
- Shared package `stream_pkg`:
  - state enum `skid_state_e` {EMPTY, BUSY, FULL}, 2-bit encoding, so monitors and later stream blocks share it
  - constant `SKID_DEPTH`=2
- Single module with no sub-module; `level` is derived combinationally from the state.
- Target size: about 150 lines of RTL.

## Test plan
- Reset:
  - Stimulus: hold `rst`=1 for 2 cycles with `in_valid`=1, `in_data`=8'h3C.
  - Required response: `out_valid`=0, `in_ready`=1, `level`=0, `out_data`=0; nothing is accepted.
- Single beat:
  - Stimulus: 8'hA5 with `out_ready`=1.
  - Required response: `out_valid`=1 with 8'hA5 the cycle after acceptance; EMPTY again one cycle later.
- Streaming:
  - Stimulus: 8'h01..8'h10 back-to-back with `out_ready`=1.
  - Required response: in order, one per cycle, no bubbles, `level` stays 1.
- Stall:
  - Stimulus: stream 8'h20, 8'h21, 8'h22; drop `out_ready` while 8'h20 is at the head.
  - Required response:
    - 8'h21 is captured in `skid_q`, `level`=2, `in_ready`=0, 8'h22 is held by the producer.
    - After `out_ready` returns: 8'h20, 8'h21, 8'h22 in order, no loss or duplication.
- Mid-operation reset:
  - Stimulus: pulse `rst` for 1 cycle while FULL.
  - Required response: next cycle `out_valid`=0, `level`=0, `in_ready`=1.
- Random stress: random `in_valid`/`out_ready` over 10k cycles with a scoreboard; the output sequence equals the input sequence.
